ipml_sync_fifo_v2: RTL and testbench

- Single-clock, parametrised FIFO for intra-domain buffering in video datapaths, e.g. line and pixel staging between processing stages that share one clock.
- Successor to the dual-clock DRM FIFO wrapper, with four additions:
  - standard or first-word-fall-through (FWFT) read mode;
  - runtime-programmable almost-full and almost-empty thresholds;
  - a synchronous flush;
  - sticky overflow and underflow error flags.
- Storage is an inferred simple dual-port RAM with 1-cycle read latency, plus an optional output register.

---
 rtl/ipml_sync_fifo_v2_if.sv | 33 +++
 rtl/ipml_sync_fifo_v2.sv | 148 ++++++++++++++
 tb/tb_ipml_sync_fifo_v2.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ipml_sync_fifo_v2_if.sv
// Handshake bundle for ipml_sync_fifo_v2: write side, read side, thresholds and status.
// The producer/consumer side uses master; the FIFO uses slave.
interface ipml_sync_fifo_v2_if #(
    parameter int c_DATA_WIDTH  = 32,
    parameter int c_DEPTH_WIDTH = 10
);
    logic                     flush;
    logic [c_DATA_WIDTH-1:0]  wr_data;
    logic                     wr_en;
    logic                     wr_full;
    logic                     almost_full;
    logic                     rd_en;
    logic [c_DATA_WIDTH-1:0]  rd_data;
    logic                     rd_empty;
    logic                     almost_empty;
    logic [c_DEPTH_WIDTH:0]   af_thresh;
    logic [c_DEPTH_WIDTH:0]   ae_thresh;
    logic [c_DEPTH_WIDTH:0]   water_level;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output flush, wr_data, wr_en, rd_en, af_thresh, ae_thresh,
        input  wr_full, almost_full, rd_data, rd_empty, almost_empty,
               water_level, overflow, underflow
    );

    modport slave (
        input  flush, wr_data, wr_en, rd_en, af_thresh, ae_thresh,
        output wr_full, almost_full, rd_data, rd_empty, almost_empty,
               water_level, overflow, underflow
    );
endinterface

// File: rtl/ipml_sync_fifo_v2.sv
// Single-clock FIFO on an inferred 1-cycle-latency RAM, with standard or FWFT read,
// programmable almost flags, synchronous flush and sticky overflow/underflow.
module ipml_sync_fifo_v2 #(
    parameter int c_DATA_WIDTH  = 32,
    parameter int c_DEPTH_WIDTH = 10,
    parameter int c_FWFT        = 0,
    parameter int c_OUTPUT_REG  = 0,
    parameter int c_RESET_DATA  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    ipml_sync_fifo_v2_if.slave   fifo
);
    localparam int DW    = c_DATA_WIDTH;
    localparam int AW    = c_DEPTH_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH_L = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] ram_dout_q;
    logic [DW-1:0] out_q;

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        afull_q, afull_d;
    logic        aempty_q, aempty_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        mid_v_q, mid_v_d;
    logic        out_v_q, out_v_d;
    logic        rd_acc_q, rd_acc_d;

    logic wr_acc, rd_acc, ram_rd, out_load, ram_empty;

    always_comb begin
        wr_acc    = fifo.wr_en && !full_q && !fifo.flush;
        rd_acc    = fifo.rd_en && !empty_q && !fifo.flush;
        ram_empty = (wr_ptr_q == rd_ptr_q);
        ram_rd    = 1'b0;
        out_load  = 1'b0;
        mid_v_d   = 1'b0;
        out_v_d   = 1'b0;
        rd_acc_d  = rd_acc;

        // FWFT keeps a two-deep prefetch (RAM output, then output register) full so pops never bubble
        if (c_FWFT != 0) begin
            out_load = mid_v_q && (!out_v_q || rd_acc);
            ram_rd   = !ram_empty && (!mid_v_q || out_load) && !fifo.flush;
            mid_v_d  = ram_rd ? 1'b1 : (out_load ? 1'b0 : mid_v_q);
            out_v_d  = out_load ? 1'b1 : (rd_acc ? 1'b0 : out_v_q);
        end else begin
            ram_rd   = rd_acc;
            out_load = (c_OUTPUT_REG != 0) && rd_acc_q;
        end

        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = ram_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        level_d = level_q;
        if (wr_acc && !rd_acc)      level_d = level_q + PTR_ONE;
        else if (!wr_acc && rd_acc) level_d = level_q - PTR_ONE;

        // Level-based full keeps total capacity at DEPTH even with FWFT prefetch words
        full_d   = (level_d == DEPTH_L);
        empty_d  = (c_FWFT != 0) ? !out_v_d : (level_d == '0);
        afull_d  = (fifo.af_thresh == '0) || (level_d >= fifo.af_thresh);
        aempty_d = (fifo.ae_thresh >= DEPTH_L) || (level_d <= fifo.ae_thresh);
        ovf_d    = ovf_q || (fifo.wr_en && full_q && !fifo.flush);
        unf_d    = unf_q || (fifo.rd_en && empty_q && !fifo.flush);

        if (fifo.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            full_d   = 1'b0;
            empty_d  = 1'b1;
            afull_d  = 1'b0;
            aempty_d = 1'b1;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            mid_v_d  = 1'b0;
            out_v_d  = 1'b0;
            rd_acc_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            mid_v_q  <= 1'b0;
            out_v_q  <= 1'b0;
            rd_acc_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            mid_v_q  <= mid_v_d;
            out_v_q  <= out_v_d;
            rd_acc_q <= rd_acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= fifo.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (c_RESET_DATA != 0) begin
                ram_dout_q <= '0;
                out_q      <= '0;
            end
        end else if (fifo.flush && (c_RESET_DATA != 0)) begin
            ram_dout_q <= '0;
            out_q      <= '0;
        end else begin
            if (ram_rd)   ram_dout_q <= mem_q[rd_ptr_q[AW-1:0]];
            if (out_load) out_q      <= ram_dout_q;
        end
    end

    assign fifo.rd_data      = ((c_FWFT != 0) || (c_OUTPUT_REG != 0)) ? out_q : ram_dout_q;
    assign fifo.wr_full      = full_q;
    assign fifo.rd_empty     = empty_q;
    assign fifo.almost_full  = afull_q;
    assign fifo.almost_empty = aempty_q;
    assign fifo.water_level  = level_q;
    assign fifo.overflow     = ovf_q;
    assign fifo.underflow    = unf_q;
endmodule

// File: tb/tb_ipml_sync_fifo_v2.sv
// Bench for ipml_sync_fifo_v2: a standard-mode and an FWFT instance, 16 words deep, 8 bits wide.
module tb_ipml_sync_fifo_v2;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ipml_sync_fifo_v2_if #(.c_DATA_WIDTH(DW), .c_DEPTH_WIDTH(AW)) s_if ();
    ipml_sync_fifo_v2_if #(.c_DATA_WIDTH(DW), .c_DEPTH_WIDTH(AW)) f_if ();

    ipml_sync_fifo_v2 #(.c_DATA_WIDTH(DW), .c_DEPTH_WIDTH(AW), .c_FWFT(0),
                        .c_OUTPUT_REG(0), .c_RESET_DATA(1))
        u_std (.clk(clk), .rst(rst), .fifo(s_if.slave));

    ipml_sync_fifo_v2 #(.c_DATA_WIDTH(DW), .c_DEPTH_WIDTH(AW), .c_FWFT(1),
                        .c_OUTPUT_REG(0), .c_RESET_DATA(1))
        u_fwft (.clk(clk), .rst(rst), .fifo(f_if.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sq[$];
    logic       m_ovf, m_unf;

    typedef struct {
        logic       fl, wr, rd;
        logic [7:0] d;
        int         lvl;
        logic       full, empty, af, ae, ovf, unf;
    } vec_t;
    vec_t tbl[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle on the standard instance and check it against the queue model.
    task automatic step_s(input logic fl, input logic wr, input logic rd,
                          input logic [7:0] d, input string tag);
        logic       full_m, empty_m, wa, ra, exp_af, exp_ae;
        logic [7:0] exp_d;
        int         lvl;
        full_m  = (sq.size() == DEPTH);
        empty_m = (sq.size() == 0);
        ra      = 1'b0;
        exp_d   = '0;
        s_if.flush   = fl;
        s_if.wr_en   = wr;
        s_if.rd_en   = rd;
        s_if.wr_data = d;
        if (fl) begin
            sq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (wr && full_m)  m_ovf = 1'b1;
            if (rd && empty_m) m_unf = 1'b1;
            wa = wr && !full_m;
            ra = rd && !empty_m;
            if (ra) exp_d = sq.pop_front();
            if (wa) sq.push_back(d);
        end
        lvl    = sq.size();
        exp_af = fl ? 1'b0 : ((int'(s_if.af_thresh) == 0) || (lvl >= int'(s_if.af_thresh)));
        exp_ae = fl ? 1'b1 : (lvl <= int'(s_if.ae_thresh));
        @(posedge clk);
        #1;
        s_if.flush = 1'b0;
        s_if.wr_en = 1'b0;
        s_if.rd_en = 1'b0;
        chk({tag, "/level"}, 32'(s_if.water_level), 32'(lvl));
        chk({tag, "/full"},  32'(s_if.wr_full),      32'(lvl == DEPTH));
        chk({tag, "/empty"}, 32'(s_if.rd_empty),     32'(lvl == 0));
        chk({tag, "/afull"}, 32'(s_if.almost_full),  32'(exp_af));
        chk({tag, "/aempty"},32'(s_if.almost_empty), 32'(exp_ae));
        chk({tag, "/ovf"},   32'(s_if.overflow),     32'(m_ovf));
        chk({tag, "/unf"},   32'(s_if.underflow),    32'(m_unf));
        if (ra) chk({tag, "/rdata"}, 32'(s_if.rd_data), 32'(exp_d));
        if (fl) chk({tag, "/rdata_clr"}, 32'(s_if.rd_data), 32'h0);
    endtask

    task automatic step_f(input logic wr, input logic rd, input logic [7:0] d);
        f_if.wr_en   = wr;
        f_if.rd_en   = rd;
        f_if.wr_data = d;
        @(posedge clk);
        #1;
        f_if.wr_en = 1'b0;
        f_if.rd_en = 1'b0;
    endtask

    initial begin
        // fl wr rd d      lvl full empty af ae ovf unf
        tbl[0] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h22, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        s_if.flush = 1'b0; s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.wr_data = '0;
        s_if.af_thresh = 5'd12; s_if.ae_thresh = 5'd3;
        f_if.flush = 1'b0; f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.wr_data = '0;
        f_if.af_thresh = 5'd12; f_if.ae_thresh = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/level",  32'(s_if.water_level),  32'h0);
        chk("rst/full",   32'(s_if.wr_full),      32'h0);
        chk("rst/empty",  32'(s_if.rd_empty),     32'h1);
        chk("rst/afull",  32'(s_if.almost_full),  32'h0);
        chk("rst/aempty", 32'(s_if.almost_empty), 32'h1);
        chk("rst/ovf",    32'(s_if.overflow),     32'h0);
        chk("rst/unf",    32'(s_if.underflow),    32'h0);
        chk("rst/rdata",  32'(s_if.rd_data),      32'h0);
        chk("rst/f_empty",32'(f_if.rd_empty),     32'h1);
        chk("rst/f_rdata",32'(f_if.rd_data),      32'h0);
        rst = 1'b0;

        // Underflow on empty, simultaneous read/write on empty, flush dropping a write
        for (int i = 0; i < 3; i++) begin
            step_s(tbl[i].fl, tbl[i].wr, tbl[i].rd, tbl[i].d, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d/t_level", i), 32'(s_if.water_level), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d/t_full", i),  32'(s_if.wr_full),      32'(tbl[i].full));
            chk($sformatf("vec%0d/t_empty", i), 32'(s_if.rd_empty),     32'(tbl[i].empty));
            chk($sformatf("vec%0d/t_af", i),    32'(s_if.almost_full),  32'(tbl[i].af));
            chk($sformatf("vec%0d/t_ae", i),    32'(s_if.almost_empty), 32'(tbl[i].ae));
            chk($sformatf("vec%0d/t_ovf", i),   32'(s_if.overflow),     32'(tbl[i].ovf));
            chk($sformatf("vec%0d/t_unf", i),   32'(s_if.underflow),    32'(tbl[i].unf));
        end

        for (int i = 0; i < DEPTH; i++) step_s(1'b0, 1'b1, 1'b0, 8'(i), $sformatf("fill%0d", i));
        chk("fill/full16", 32'(s_if.wr_full), 32'h1);
        chk("fill/level16", 32'(s_if.water_level), 32'd16);
        step_s(1'b0, 1'b1, 1'b0, 8'hEE, "wr17");
        chk("wr17/ovf", 32'(s_if.overflow), 32'h1);

        for (int i = 0; i < 5; i++) step_s(1'b0, 1'b0, 1'b1, 8'h00, $sformatf("rd%0d", i));
        s_if.af_thresh = 5'd10;
        step_s(1'b0, 1'b0, 1'b0, 8'h00, "afchg");
        chk("afchg/af_at11", 32'(s_if.almost_full), 32'h1);
        s_if.af_thresh = 5'd12;
        step_s(1'b0, 1'b0, 1'b0, 8'h00, "afrestore");
        for (int i = 5; i < DEPTH; i++) step_s(1'b0, 1'b0, 1'b1, 8'h00, $sformatf("rd%0d", i));
        step_s(1'b1, 1'b0, 1'b0, 8'h00, "clr");

        for (int i = 0; i < 8; i++) step_s(1'b0, 1'b1, 1'b0, 8'($urandom), "pre8");
        for (int i = 0; i < 100; i++) step_s(1'b0, 1'b1, 1'b1, 8'($urandom), $sformatf("rw%0d", i));
        chk("rw/level8", 32'(s_if.water_level), 32'd8);
        step_s(1'b0, 1'b1, 1'b0, 8'h55, "to9");
        step_s(1'b1, 1'b1, 1'b0, 8'h77, "flush9");
        chk("flush9/level", 32'(s_if.water_level), 32'h0);
        chk("flush9/ovf",   32'(s_if.overflow),    32'h0);

        for (int i = 0; i < 3; i++) step_s(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i), "burst");
        #2 rst = 1'b1;
        #1;
        chk("arst/level", 32'(s_if.water_level), 32'h0);
        chk("arst/empty", 32'(s_if.rd_empty),    32'h1);
        chk("arst/full",  32'(s_if.wr_full),     32'h0);
        chk("arst/rdata", 32'(s_if.rd_data),     32'h0);
        sq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1 rst = 1'b0;

        step_f(1'b1, 1'b0, 8'hA5);
        chk("fwft/N_level", 32'(f_if.water_level), 32'h1);
        chk("fwft/N_empty", 32'(f_if.rd_empty),    32'h1);
        step_f(1'b0, 1'b1, 8'h00);
        chk("fwft/N1_empty", 32'(f_if.rd_empty),   32'h1);
        chk("fwft/N1_unf",   32'(f_if.underflow),  32'h1);
        chk("fwft/N1_level", 32'(f_if.water_level),32'h1);
        step_f(1'b0, 1'b0, 8'h00);
        chk("fwft/N2_empty", 32'(f_if.rd_empty),   32'h0);
        chk("fwft/N2_rdata", 32'(f_if.rd_data),    32'hA5);
        step_f(1'b0, 1'b1, 8'h00);
        chk("fwft/pop_empty", 32'(f_if.rd_empty),   32'h1);
        chk("fwft/pop_level", 32'(f_if.water_level),32'h0);
        for (int i = 0; i < 8; i++) step_f(1'b1, 1'b0, 8'(8'h30 + i));
        step_f(1'b0, 1'b0, 8'h00);
        step_f(1'b0, 1'b0, 8'h00);
        chk("fwft/level8", 32'(f_if.water_level), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fwft/b2b%0d_empty", i), 32'(f_if.rd_empty), 32'h0);
            chk($sformatf("fwft/b2b%0d_data", i),  32'(f_if.rd_data),  32'(8'h30 + i));
            step_f(1'b0, 1'b1, 8'h00);
        end
        chk("fwft/drain_empty", 32'(f_if.rd_empty),    32'h1);
        chk("fwft/drain_level", 32'(f_if.water_level), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
